// File: rtl/ifu_prefetch.sv
// ifu_prefetch: owns the fetch PC, issues credit-limited word fetches and buffers responses in an in-order FIFO.
// Define IFU_BYPASS_EN to forward a response straight to the outputs when the FIFO is empty.
module ifu_prefetch #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_en_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          hold_flag_i,
  output logic          ibus_req_o,
  output logic [AW-1:0] ibus_addr_o,
  input  logic          ibus_gnt_i,
  input  logic          ibus_rvalid_i,
  input  logic [DW-1:0] ibus_rdata_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  logic [AW-1:0] pc_q, pc_d, last_addr_q;
  logic [DW-1:0] last_data_q;
  logic [CW-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, tw_q, tw_d, tr_q, tr_d;
  logic [DW-1:0] fd_q [FIFO_DEPTH];
  logic [AW-1:0] fa_q [FIFO_DEPTH];
  logic [AW-1:0] tag_q [FIFO_DEPTH];
  logic issue, take, byp, push, pop, empty;
  assign empty = count_q == '0;
  // Outstanding fetches (including ones marked for drop) reserve FIFO space.
  assign ibus_req_o = !rst && !jump_en_i && ({1'b0, count_q} + {1'b0, out_q} < SW'(FIFO_DEPTH));
  assign ibus_addr_o = pc_q;
  assign issue = ibus_req_o && ibus_gnt_i;
  assign take = ibus_rvalid_i && drop_q == '0 && !jump_en_i;
`ifdef IFU_BYPASS_EN
  assign byp = take && empty;
`else
  assign byp = 1'b0;
`endif
  assign pop = !empty && !jump_en_i && !hold_flag_i;
  assign push = take && !(byp && !hold_flag_i);
  assign inst_valid_o = (!empty || byp) && !jump_en_i;
  assign inst_o = byp ? ibus_rdata_i : !empty ? fd_q[rd_q] : last_data_q;
  assign inst_addr_o = byp ? tag_q[tr_q] : !empty ? fa_q[rd_q] : last_addr_q;
  always_comb begin
    pc_d = jump_en_i ? jump_addr_i & ~AW'(3) : issue ? pc_q + AW'(4) : pc_q;
    out_d = out_q + CW'(issue) - CW'(ibus_rvalid_i);
    drop_d = jump_en_i ? out_q - CW'(ibus_rvalid_i) : drop_q - CW'(ibus_rvalid_i && drop_q != '0);
    count_d = jump_en_i ? '0 : count_q + CW'(push) - CW'(pop);
    wr_d = wr_q + PW'(push);
    rd_d = jump_en_i ? wr_q : rd_q + PW'(pop);
    tw_d = tw_q + PW'(issue);
    tr_d = tr_q + PW'(ibus_rvalid_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      count_q <= '0;
      out_q <= '0;
      drop_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      tw_q <= '0;
      tr_q <= '0;
      last_data_q <= '0;
      last_addr_q <= '0;
    end else begin
      pc_q <= pc_d;
      count_q <= count_d;
      out_q <= out_d;
      drop_q <= drop_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      tw_q <= tw_d;
      tr_q <= tr_d;
      last_data_q <= inst_o;
      last_addr_q <= inst_addr_o;
    end
  end
  // Tags stay in issue order; dropped responses consume their tag too.
  always_ff @(posedge clk) begin
    if (issue) tag_q[tw_q] <= pc_q;
    if (push) begin
      fd_q[wr_q] <= ibus_rdata_i;
      fa_q[wr_q] <= tag_q[tr_q];
    end
  end
  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst) ibus_rvalid_i |-> out_q != '0);
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: in-order bus model plus a fetch-stream model checked every cycle, with directed literal checks.
module tb_ifu_prefetch;
`ifdef IFU_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic jump_en_i = 1'b0, hold_flag_i = 1'b0, ibus_gnt_i = 1'b0, ibus_rvalid_i = 1'b0;
  logic [31:0] jump_addr_i = '0, ibus_rdata_i = '0;
  logic ibus_req_o, inst_valid_o;
  logic [31:0] ibus_addr_o, inst_o, inst_addr_o;
  ifu_prefetch #(.DW(32), .AW(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
    .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] addr; int due; bit drop; } req_t;
  req_t pend[$];
  logic [31:0] live[$];
  logic [31:0] exp_pc, last_a, last_d;
  bit jumped, gnt_on;
  int cy, rd, checks = 0, errors = 0;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cy);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    live.delete();
    exp_pc = 32'h0;
    last_a = '0;
    last_d = '0;
    jumped = 1'b0;
    cy = 0;
  endtask
  task automatic model_step(input bit j, input bit h, input logic [31:0] ja);
    int lp = 0, nb;
    bit bp, ev, ereq;
    foreach (pend[i]) if (!pend[i].drop) lp++;
    nb = live.size() - lp;
    bp = BYP && ibus_rvalid_i && !pend[0].drop && !j && nb == 0;
    ev = !j && (nb > 0 || bp);
    ereq = !j && (pend.size() + nb < DEPTH);
    cmp("ibus_req", 32'(ibus_req_o), 32'(ereq));
    if (ereq) cmp("ibus_addr", ibus_addr_o, exp_pc);
    cmp("inst_valid", 32'(inst_valid_o), 32'(ev));
    if (ev) begin
      cmp("inst_addr", inst_addr_o, live[0]);
      cmp("inst_data", inst_o, f(live[0]));
      last_a = live[0];
      last_d = f(live[0]);
      jumped = 1'b0;
    end else if (!j && !jumped) begin
      cmp("held_addr", inst_addr_o, last_a);
      cmp("held_data", inst_o, last_d);
    end
    if (ev && !h) void'(live.pop_front());
    if (ibus_rvalid_i) void'(pend.pop_front());
    if (j) begin
      live.delete();
      foreach (pend[i]) pend[i].drop = 1'b1;
      exp_pc = ja & ~32'h3;
      jumped = 1'b1;
    end else if (ereq && gnt_on) begin
      pend.push_back('{exp_pc, cy + rd, 1'b0});
      live.push_back(exp_pc);
      exp_pc += 32'h4;
    end
  endtask
  task automatic cyc(input bit j, input bit h, input logic [31:0] ja);
    @(negedge clk);
    jump_en_i = j;
    hold_flag_i = h;
    jump_addr_i = ja;
    ibus_gnt_i = gnt_on;
    ibus_rvalid_i = pend.size() > 0 && pend[0].due <= cy;
    ibus_rdata_i = ibus_rvalid_i ? f(pend[0].addr) : '0;
    #4;
    model_step(j, h, ja);
    cy++;
  endtask
  task automatic next_valid(input string n, input logic [31:0] e);
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      cyc(1'b0, 1'b0, '0);
      if (inst_valid_o) begin
        got = 1'b1;
        cmp(n, inst_addr_o, e);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no valid instruction within 30 cycles, expected %h", n, e);
    end
  endtask
  task automatic idle_inputs();
    jump_en_i = 1'b0;
    hold_flag_i = 1'b0;
    ibus_gnt_i = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
  initial begin
    model_reset();
    gnt_on = 1'b0;
    rd = 1;
    #12;
    cmp("rst_req", 32'(ibus_req_o), 32'h0);
    cmp("rst_valid", 32'(inst_valid_o), 32'h0);
    cmp("rst_inst", inst_o, 32'h0);
    cmp("rst_inst_addr", inst_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    // Streaming from reset: grant at cycle 0, rvalid at cycle 1.
    gnt_on = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cmp("c0_addr", ibus_addr_o, 32'h0);
    cmp("c0_req", 32'(ibus_req_o), 32'h1);
    cmp("c0_valid", 32'(inst_valid_o), 32'h0);
    cyc(1'b0, 1'b0, '0);
    cmp("c1_addr", ibus_addr_o, 32'h4);
    cmp("c1_valid", 32'(inst_valid_o), 32'(BYP));
    cyc(1'b0, 1'b0, '0);
    cmp("c2_addr", ibus_addr_o, 32'h8);
    cmp("c2_valid", 32'(inst_valid_o), 32'h1);
    cmp("c2_inst_addr", inst_addr_o, BYP ? 32'h4 : 32'h0);
    cmp("c2_req", 32'(ibus_req_o), 32'(BYP));
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0);
    // Hold for 5 cycles: credit runs out, head frozen.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, '0);
    cmp("hold_req", 32'(ibus_req_o), 32'h0);
    cmp("hold_valid", 32'(inst_valid_o), 32'h1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0);
    // Jump with two fetches in flight.
    gnt_on = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0);
    gnt_on = 1'b1;
    rd = 3;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    cmp("pre_jump_req", 32'(ibus_req_o), 32'h1);
    cyc(1'b1, 1'b0, 32'h103);
    cmp("jump_req", 32'(ibus_req_o), 32'h0);
    cmp("jump_valid", 32'(inst_valid_o), 32'h0);
    next_valid("jump_first", 32'h100);
    next_valid("jump_second", 32'h104);
    // Jump coinciding with a response while held.
    rd = 1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, '0);
      if (ibus_req_o && gnt_on) break;
    end
    cyc(1'b1, 1'b1, 32'h200);
    cmp("jump_rv_valid", 32'(inst_valid_o), 32'h0);
    next_valid("jump_rv_target", 32'h200);
    // Grant withheld for 3 cycles, then slow responses.
    gnt_on = 1'b0;
    cyc(1'b1, 1'b0, 32'h300);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, '0);
      cmp("nogrant_addr", ibus_addr_o, 32'h300);
    end
    gnt_on = 1'b1;
    rd = 4;
    next_valid("slow_0", 32'h300);
    next_valid("slow_1", 32'h304);
    next_valid("slow_2", 32'h308);
    // Fill the FIFO, then reset asynchronously mid-cycle.
    rd = 1;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, '0);
    cmp("full_valid", 32'(inst_valid_o), 32'h1);
    cmp("full_req", 32'(ibus_req_o), 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmp("async_req", 32'(ibus_req_o), 32'h0);
    cmp("async_valid", 32'(inst_valid_o), 32'h0);
    cmp("async_inst", inst_o, 32'h0);
    cmp("async_inst_addr", inst_addr_o, 32'h0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, '0);
    cmp("post_rst_addr", ibus_addr_o, 32'h0);
    cmp("post_rst_req", 32'(ibus_req_o), 32'h1);
    next_valid("post_rst_first", 32'h0);
    next_valid("post_rst_second", 32'h4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
